// File: rtl/rgb_to_yuv422_prog.sv
`default_nettype none
// ============================================================================
// Module   : rgb_to_yuv422_prog
// Brief    : RGB stream to planar Y/U/V 4:2:2 with runtime-loaded coefficients,
//            per-frame pixel count and independent per-stream output FIFOs.
// Revision : 1.0
// ============================================================================
module rgb_to_yuv422_prog #(
    parameter int DW         = 8,
    parameter int CW         = 9,
    parameter int FRAC       = 7,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rgb_valid,
    output logic                   rgb_ready,
    input  logic [2:0][DW-1:0]     rgb_data,
    input  logic                   pixel_count_valid,
    output logic                   pixel_count_ready,
    input  logic [CNT_W-1:0]       pixel_count,
    input  logic                   coeff_valid,
    output logic                   coeff_ready,
    input  logic [CW-1:0]          coeff_data,
    output logic                   y_valid,
    input  logic                   y_ready,
    output logic [DW-1:0]          y_data,
    output logic                   u_valid,
    input  logic                   u_ready,
    output logic [DW-1:0]          u_data,
    output logic                   v_valid,
    input  logic                   v_ready,
    output logic [DW-1:0]          v_data
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = DW + 1 + CW;
    localparam int SW  = DW + CW + 3;
    localparam int CTW = AW + 3;

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic signed [SW-1:0] c_HALF = SW'(2**(FRAC-1));
    localparam logic signed [SW-1:0] c_ONE  = SW'(2**FRAC);
    localparam logic signed [SW-1:0] c_OFF  = SW'(2**(DW-1));
    localparam logic signed [SW-1:0] c_MAX  = SW'(2**DW - 1);

    logic [1:0]                r_state;
    logic [3:0]                r_idx;
    logic signed [CW-1:0]      r_coef [9];
    logic [CNT_W-1:0]          r_remaining;
    logic                      r_par;
    logic                      r_in_valid, r_in_last;
    logic [2:0][DW-1:0]        r_in_rgb;
    logic                      r_s1_valid, r_s1_last;
    logic signed [PW-1:0]      r_prod [9];
    logic signed [SW-1:0]      r_su_hold, r_sv_hold;

    logic                      w_coeff_acc, w_cnt_acc, w_pix_acc, w_frame_start;
    logic [CTW-1:0]            w_inflight;
    logic [2:0]                w_room, w_push, w_ready, w_valid;
    logic [AW:0]               w_cnt [3];
    logic [DW-1:0]             w_wdata [3];
    logic [DW-1:0]             w_rdata [3];
    logic signed [SW-1:0]      w_sy, w_su, w_sv;

    function automatic logic [DW-1:0] f_clamp(input logic signed [SW-1:0] x);
        if (x[SW-1])
            return '0;
        else if (x > c_MAX)
            return '1;
        else
            return x[DW-1:0];
    endfunction

    assign coeff_ready       = (r_state == S_LOAD) | (r_state == S_WAIT);
    assign pixel_count_ready = (r_state == S_WAIT);
    assign w_coeff_acc       = coeff_valid & coeff_ready;
    // A coefficient arriving together with a count takes priority.
    assign w_cnt_acc         = pixel_count_valid & pixel_count_ready & ~coeff_valid;
    assign w_frame_start     = w_cnt_acc & (pixel_count != '0);

    // Pixels already in the pipeline are treated as future pushes to every FIFO.
    assign w_inflight = CTW'(r_in_valid) + CTW'(r_s1_valid);
    assign w_room[0]  = (CTW'(w_cnt[0]) + w_inflight + CTW'(3)) <= CTW'(FIFO_DEPTH);
    assign w_room[1]  = (CTW'(w_cnt[1]) + w_inflight + CTW'(2)) <= CTW'(FIFO_DEPTH);
    assign w_room[2]  = (CTW'(w_cnt[2]) + w_inflight + CTW'(2)) <= CTW'(FIFO_DEPTH);
    assign rgb_ready  = (r_state == S_RUN) & (r_remaining != '0) & (&w_room);
    assign w_pix_acc  = rgb_valid & rgb_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_LOAD;
            r_idx       <= '0;
            r_remaining <= '0;
            for (int k = 0; k < 9; k++) r_coef[k] <= '0;
        end else begin
            case (r_state)
                S_LOAD: if (w_coeff_acc) begin
                    r_coef[r_idx] <= coeff_data;
                    if (r_idx == 4'd8) begin
                        r_idx   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_WAIT: if (w_coeff_acc) begin
                    r_coef[0] <= coeff_data;
                    r_idx     <= 4'd1;
                    r_state   <= S_LOAD;
                end else if (w_frame_start) begin
                    r_remaining <= pixel_count;
                    r_state     <= S_RUN;
                end
                S_RUN: if (w_pix_acc) begin
                    r_remaining <= r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) r_state <= S_DRAIN;
                end
                default: if (!r_in_valid && !r_s1_valid) r_state <= S_WAIT;
            endcase
        end
    end

    assign w_sy = SW'(r_prod[0]) + SW'(r_prod[1]) + SW'(r_prod[2]);
    assign w_su = SW'(r_prod[3]) + SW'(r_prod[4]) + SW'(r_prod[5]);
    assign w_sv = SW'(r_prod[6]) + SW'(r_prod[7]) + SW'(r_prod[8]);

    // Chroma is pushed on the odd pixel of a pair, or alone on an unpaired last pixel.
    assign w_push[0]  = r_s1_valid;
    assign w_push[1]  = r_s1_valid & (r_par | r_s1_last);
    assign w_push[2]  = w_push[1];
    assign w_wdata[0] = f_clamp((w_sy + c_HALF) >>> FRAC);
    assign w_wdata[1] = r_par ? f_clamp(((r_su_hold + w_su + c_ONE) >>> (FRAC+1)) + c_OFF)
                              : f_clamp(((w_su + c_HALF) >>> FRAC) + c_OFF);
    assign w_wdata[2] = r_par ? f_clamp(((r_sv_hold + w_sv + c_ONE) >>> (FRAC+1)) + c_OFF)
                              : f_clamp(((w_sv + c_HALF) >>> FRAC) + c_OFF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_valid <= 1'b0;
            r_in_last  <= 1'b0;
            r_in_rgb   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_par      <= 1'b0;
            r_su_hold  <= '0;
            r_sv_hold  <= '0;
            for (int k = 0; k < 9; k++) r_prod[k] <= '0;
        end else begin
            r_in_valid <= w_pix_acc;
            if (w_pix_acc) begin
                r_in_rgb  <= rgb_data;
                r_in_last <= (r_remaining == CNT_W'(1));
            end
            r_s1_valid <= r_in_valid;
            if (r_in_valid) begin
                r_s1_last <= r_in_last;
                for (int k = 0; k < 9; k++)
                    r_prod[k] <= $signed(PW'(r_in_rgb[k % 3])) * PW'(r_coef[k]);
            end
            if (w_frame_start) begin
                r_par <= 1'b0;
            end else if (r_s1_valid) begin
                if (!r_par && !r_s1_last) begin
                    r_su_hold <= w_su;
                    r_sv_hold <= w_sv;
                    r_par     <= 1'b1;
                end else begin
                    r_par <= 1'b0;
                end
            end
        end
    end

    assign w_ready = {v_ready, u_ready, y_ready};

    for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
        logic [DW-1:0] r_mem [FIFO_DEPTH];
        logic [AW-1:0] r_wp, r_rp;
        logic [AW:0]   r_cnt;
        logic          w_pop, w_wr;

        assign w_pop = (r_cnt != '0) & w_ready[gi];
        assign w_wr  = w_push[gi] & ((r_cnt != (AW+1)'(FIFO_DEPTH)) | w_pop);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
                for (int j = 0; j < FIFO_DEPTH; j++) r_mem[j] <= '0;
            end else begin
                if (w_wr) begin
                    r_mem[r_wp] <= w_wdata[gi];
                    r_wp        <= r_wp + AW'(1);
                end
                if (w_pop) r_rp <= r_rp + AW'(1);
                r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            end
        end

        assign w_cnt[gi]   = r_cnt;
        assign w_valid[gi] = (r_cnt != '0);
        assign w_rdata[gi] = r_mem[r_rp];
    end

    assign y_valid = w_valid[0];
    assign u_valid = w_valid[1];
    assign v_valid = w_valid[2];
    assign y_data  = w_rdata[0];
    assign u_data  = w_rdata[1];
    assign v_data  = w_rdata[2];

endmodule
`default_nettype wire

// File: tb/tb_rgb_to_yuv422_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_to_yuv422_prog
// Brief    : Directed self-checking bench for rgb_to_yuv422_prog.
// Revision : 1.0
// ============================================================================
module tb_rgb_to_yuv422_prog;
    localparam int DW = 8, CW = 9, FRAC = 7, CNT_W = 16, FIFO_DEPTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               rgb_valid = 1'b0, rgb_ready;
    logic [2:0][DW-1:0] rgb_data = '0;
    logic               pixel_count_valid = 1'b0, pixel_count_ready;
    logic [CNT_W-1:0]   pixel_count = '0;
    logic               coeff_valid = 1'b0, coeff_ready;
    logic [CW-1:0]      coeff_data = '0;
    logic               y_valid, u_valid, v_valid;
    logic               y_ready = 1'b1, u_ready = 1'b1, v_ready = 1'b1;
    logic [DW-1:0]      y_data, u_data, v_data;

    rgb_to_yuv422_prog #(.DW(DW), .CW(CW), .FRAC(FRAC), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .rgb_valid(rgb_valid), .rgb_ready(rgb_ready), .rgb_data(rgb_data),
        .pixel_count_valid(pixel_count_valid), .pixel_count_ready(pixel_count_ready),
        .pixel_count(pixel_count),
        .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff_data(coeff_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
        .u_valid(u_valid), .u_ready(u_ready), .u_data(u_data),
        .v_valid(v_valid), .v_ready(v_ready), .v_data(v_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int yq[$], uq[$], vq[$];
    int coefs[9] = '{38, 75, 15, -22, -42, 64, 64, -54, -10};
    int pr[16], pg[16], pb[16];
    int n_acc;
    logic done;

    always @(negedge clk) begin
        if (rst && y_valid && y_ready) yq.push_back(int'(y_data));
        if (rst && u_valid && u_ready) uq.push_back(int'(u_data));
        if (rst && v_valid && v_ready) vq.push_back(int'(v_data));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int x);
        return (x < 0) ? 0 : (x > 255) ? 255 : x;
    endfunction
    function automatic int m_y(input int r, input int g, input int b);
        return clampi((38*r + 75*g + 15*b + 64) >>> 7);
    endfunction
    function automatic int m_su(input int r, input int g, input int b);
        return -22*r - 42*g + 64*b;
    endfunction
    function automatic int m_sv(input int r, input int g, input int b);
        return 64*r - 54*g - 10*b;
    endfunction
    function automatic int m_pair(input int a, input int b);
        return clampi(((a + b + 128) >>> 8) + 128);
    endfunction

    task automatic send_coeff(input int c);
        int n = 0;
        coeff_valid = 1'b1;
        coeff_data  = c[CW-1:0];
        do begin @(negedge clk); n++; end while (!coeff_ready && n < 300);
        chk("coeff_hs", coeff_ready, 1);
        @(posedge clk); #1;
        coeff_valid = 1'b0;
    endtask

    task automatic send_count(input int c);
        int n = 0;
        pixel_count_valid = 1'b1;
        pixel_count       = c[CNT_W-1:0];
        do begin @(negedge clk); n++; end while (!pixel_count_ready && n < 300);
        chk("count_hs", pixel_count_ready, 1);
        @(posedge clk); #1;
        pixel_count_valid = 1'b0;
    endtask

    task automatic send_pix(input int r, input int g, input int b);
        int n = 0;
        rgb_valid = 1'b1;
        rgb_data  = {b[DW-1:0], g[DW-1:0], r[DW-1:0]};
        do begin @(negedge clk); n++; end while (!rgb_ready && n < 300);
        chk("pix_hs", rgb_ready, 1);
        @(posedge clk); #1;
        rgb_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int ny, input int nu, input int nv);
        int n = 0;
        while (!(yq.size() >= ny && uq.size() >= nu && vq.size() >= nv) && n < 400) begin
            @(negedge clk); n++;
        end
        repeat (6) @(negedge clk);
        chk({tag, "_ny"}, yq.size(), ny);
        chk({tag, "_nu"}, uq.size(), nu);
        chk({tag, "_nv"}, vq.size(), nv);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!pixel_count_ready && n < 100) begin @(negedge clk); n++; end
        chk(tag, pixel_count_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic clearq();
        yq.delete(); uq.delete(); vq.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_yv", y_valid, 0);
        chk("rst_uv", u_valid, 0);
        chk("rst_vv", v_valid, 0);
        chk("rst_yd", y_data, 0);
        chk("rst_rgbrdy", rgb_ready, 0);
        chk("rst_cntrdy", pixel_count_ready, 0);
        chk("rst_coefrdy", coeff_ready, 1);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) send_coeff(coefs[i]);
        @(negedge clk);
        chk("load_done", pixel_count_ready, 1);
        @(posedge clk); #1;

        // White then black
        clearq();
        send_count(2);
        send_pix(255, 255, 255);
        send_pix(0, 0, 0);
        wait_out("f1", 2, 1, 1);
        chk("f1_y0", yq[0], 255);
        chk("f1_y1", yq[1], 0);
        chk("f1_u", uq[0], 128);
        chk("f1_v", vq[0], 128);
        wait_idle("f1_idle");

        // Red then black
        clearq();
        send_count(2);
        send_pix(255, 0, 0);
        send_pix(0, 0, 0);
        wait_out("f2", 2, 1, 1);
        chk("f2_y0", yq[0], 76);
        chk("f2_y1", yq[1], 0);
        chk("f2_u", uq[0], 106);
        chk("f2_v", vq[0], 192);
        wait_idle("f2_idle");

        // Single unpaired pixel, V clamps
        clearq();
        send_count(1);
        send_pix(255, 0, 0);
        chk("f3_rdy_low", rgb_ready, 0);
        wait_out("f3", 1, 1, 1);
        chk("f3_y", yq[0], 76);
        chk("f3_u", uq[0], 84);
        chk("f3_v", vq[0], 255);
        wait_idle("f3_idle");

        // Y backpressure
        clearq();
        for (int i = 0; i < 16; i++) begin
            pr[i] = $urandom_range(0, 255);
            pg[i] = $urandom_range(0, 255);
            pb[i] = $urandom_range(0, 255);
        end
        y_ready = 1'b0;
        n_acc = 0;
        done = 1'b0;
        send_count(16);
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send_pix(pr[i], pg[i], pb[i]);
                    n_acc++;
                end
                done = 1'b1;
            end
        join_none
        repeat (40) @(negedge clk);
        chk("stall_rdy", rgb_ready, 0);
        chk("stall_yv", y_valid, 1);
        chk("stall_ypop", yq.size(), 0);
        chk("stall_acc_le4", (n_acc <= 4 && n_acc > 0), 1);
        @(posedge clk); #1;
        y_ready = 1'b1;
        for (int n = 0; n < 1000 && !done; n++) @(negedge clk);
        chk("stall_done", done, 1);
        wait_out("f4", 16, 8, 8);
        for (int i = 0; i < 16 && i < yq.size(); i++)
            chk($sformatf("f4_y%0d", i), yq[i], m_y(pr[i], pg[i], pb[i]));
        for (int i = 0; i < 8 && i < uq.size() && i < vq.size(); i++) begin
            chk($sformatf("f4_u%0d", i), uq[i],
                m_pair(m_su(pr[2*i], pg[2*i], pb[2*i]), m_su(pr[2*i+1], pg[2*i+1], pb[2*i+1])));
            chk($sformatf("f4_v%0d", i), vq[i],
                m_pair(m_sv(pr[2*i], pg[2*i], pb[2*i]), m_sv(pr[2*i+1], pg[2*i+1], pb[2*i+1])));
        end
        wait_idle("f4_idle");

        // Coefficient and count offered together
        clearq();
        coeff_valid = 1'b1; coeff_data = 9'd38;
        pixel_count_valid = 1'b1; pixel_count = 16'd5;
        @(negedge clk);
        chk("both_coefrdy", coeff_ready, 1);
        @(posedge clk); #1;
        coeff_valid = 1'b0; pixel_count_valid = 1'b0;
        @(negedge clk);
        chk("both_load", pixel_count_ready, 0);
        chk("both_coefrdy2", coeff_ready, 1);
        chk("both_idx", dut.r_idx, 1);
        @(posedge clk); #1;
        for (int i = 1; i < 9; i++) send_coeff(coefs[i]);
        send_count(0);
        repeat (10) @(negedge clk);
        chk("zero_wait", pixel_count_ready, 1);
        chk("zero_rgbrdy", rgb_ready, 0);
        chk("zero_ny", yq.size(), 0);
        chk("zero_yv", y_valid, 0);
        @(posedge clk); #1;

        // Reset during a frame with pending outputs
        y_ready = 1'b0;
        send_count(4);
        send_pix(10, 200, 30);
        send_pix(255, 255, 0);
        repeat (6) @(negedge clk);
        chk("pend_yv", y_valid, 1);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("arst_yv", y_valid, 0);
        chk("arst_uv", u_valid, 0);
        chk("arst_vv", v_valid, 0);
        chk("arst_coefrdy", coeff_ready, 1);
        chk("arst_rgbrdy", rgb_ready, 0);
        chk("arst_coef0", dut.r_coef[0], 0);
        @(posedge clk); #1;
        rst = 1'b1;
        y_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_yv", y_valid, 0);
        chk("post_rst_cntrdy", pixel_count_ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
